// File: rtl/proc_pkg.sv
// ============================================================================
// Module   : proc_pkg
// Purpose  : Shared states, fault codes, NOP word and default field widths
//            for the 8-bit processor datapath.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package proc_pkg;

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  localparam logic [1:0] FC_NONE   = 2'd0;
  localparam logic [1:0] FC_RANGE  = 2'd1;
  localparam logic [1:0] FC_PARITY = 2'd2;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_OPC_W  = 3;
  localparam int DEF_RS_W   = 2;

  localparam logic [DEF_DATA_W-1:0] NOP = '0;

endpackage

`default_nettype wire

// File: rtl/instr_field_decode.sv
// ============================================================================
// Module   : instr_field_decode
// Purpose  : Splits an instruction word into opcode, Rs and a sign-extended
//            immediate; the immediate spans every bit below the opcode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_field_decode
  import proc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int OPC_W  = DEF_OPC_W,
  parameter int RS_W   = DEF_RS_W
) (
  input  logic [DATA_W-1:0] i_instr,
  output logic [OPC_W-1:0]  o_opcode,
  output logic [RS_W-1:0]   o_rs,
  output logic [DATA_W-1:0] o_imm_ext
);

  localparam int IMM_W = DATA_W - OPC_W;

  assign o_opcode  = i_instr[DATA_W-1 -: OPC_W];
  assign o_rs      = i_instr[DATA_W-OPC_W-1 -: RS_W];
  assign o_imm_ext = {{OPC_W{i_instr[IMM_W-1]}}, i_instr[IMM_W-1:0]};

endmodule

`default_nettype wire

// File: rtl/instr_fetch_mem.sv
// ============================================================================
// Module   : instr_fetch_mem
// Purpose  : Loadable instruction memory with registered, stallable fetch,
//            field decode and sticky range/parity fault.
//            Optional macro PARITY_CHECK_EN adds a stored even-parity bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_mem
  import proc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int OPC_W  = DEF_OPC_W,
  parameter int RS_W   = DEF_RS_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              run_start,
  input  logic [ADDR_W-1:0] pccounter,
  input  logic              fetch_req,
  input  logic              stall,
  output logic [DATA_W-1:0] instr_q,
  output logic              instr_valid,
  output logic [OPC_W-1:0]  saidacontrolunit,
  output logic [RS_W-1:0]   saidaRs,
  output logic [DATA_W-1:0] saidaextendsinal,
  output logic              load_err,
  output logic              fault,
  output logic [1:0]        fault_code,
  output logic [1:0]        state_o
);

  localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] instr_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              fault_q, fault_d;
  logic [1:0]        code_q, code_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  // Compare with one extra bit so DEPTH == 2**ADDR_W is still representable.
  logic              load_in_range, pc_in_range, par_err;
  logic [IDX_W-1:0]  load_idx, pc_idx;

  assign load_in_range = {1'b0, load_addr} < DEPTH_LIM;
  assign pc_in_range   = {1'b0, pccounter} < DEPTH_LIM;
  assign load_idx      = load_addr[IDX_W-1:0];
  assign pc_idx        = pccounter[IDX_W-1:0];

`ifdef PARITY_CHECK_EN
  logic par_q [DEPTH];
  logic par_d [DEPTH];
  assign par_err = ^{mem_q[pc_idx], par_q[pc_idx]};
`else
  assign par_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    fault_d = fault_q;
    code_d  = code_q;
    mem_d   = mem_q;
`ifdef PARITY_CHECK_EN
    par_d   = par_q;
`endif
    case (state_q)
      ST_LOAD: begin
        valid_d = 1'b0;
        if (load_we) begin
          if (load_in_range) begin
            mem_d[load_idx] = load_data;
`ifdef PARITY_CHECK_EN
            par_d[load_idx] = ^load_data;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
        if (run_start) state_d = ST_RUN;
      end
      ST_RUN: begin
        err_d = load_we;
        if (!stall) begin
          if (fetch_req) begin
            if (!pc_in_range || par_err) begin
              state_d = ST_FAULT;
              instr_d = DATA_W'(NOP);
              valid_d = 1'b0;
              fault_d = 1'b1;
              code_d  = pc_in_range ? FC_PARITY : FC_RANGE;
            end else begin
              instr_d = mem_q[pc_idx];
              valid_d = 1'b1;
            end
          end else begin
            valid_d = 1'b0;
          end
        end
      end
      ST_FAULT: begin
        valid_d = 1'b0;
        fault_d = 1'b1;
      end
      default: begin
        state_d = ST_LOAD;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_LOAD;
      instr_q <= DATA_W'(NOP);
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      fault_q <= 1'b0;
      code_q  <= FC_NONE;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= DATA_W'(NOP);
`ifdef PARITY_CHECK_EN
        par_q[i] <= 1'b0;
`endif
      end
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      fault_q <= fault_d;
      code_q  <= code_d;
      mem_q   <= mem_d;
`ifdef PARITY_CHECK_EN
      par_q   <= par_d;
`endif
    end
  end

  assign instr_valid = valid_q;
  assign load_err    = err_q;
  assign fault       = fault_q;
  assign fault_code  = code_q;
  assign state_o     = state_q;

  instr_field_decode #(
    .DATA_W (DATA_W),
    .OPC_W  (OPC_W),
    .RS_W   (RS_W)
  ) u_decode (
    .i_instr   (instr_q),
    .o_opcode  (saidacontrolunit),
    .o_rs      (saidaRs),
    .o_imm_ext (saidaextendsinal)
  );

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_mem.sv
// ============================================================================
// Module   : tb_instr_fetch_mem
// Purpose  : Directed plus randomized check of instr_fetch_mem against a
//            mode/array reference model, compared after every clock edge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_mem;

  localparam int DEPTH = 16;

  logic       clock = 1'b0;
  logic       reset, load_we, run_start, fetch_req, stall;
  logic [7:0] load_addr, load_data, pccounter;
  logic [7:0] instr_q, saidaextendsinal;
  logic       instr_valid, load_err, fault;
  logic [2:0] saidacontrolunit;
  logic [1:0] saidaRs, fault_code, state_o;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0=LOAD 1=RUN 2=FAULT
  int         m_mode;
  logic [7:0] m_mem [DEPTH];
  logic [7:0] m_instr;
  logic       m_valid, m_err, m_fault;
  logic [1:0] m_code;

  always #5 clock = ~clock;

  instr_fetch_mem dut (
    .clock            (clock),
    .reset            (reset),
    .load_we          (load_we),
    .load_addr        (load_addr),
    .load_data        (load_data),
    .run_start        (run_start),
    .pccounter        (pccounter),
    .fetch_req        (fetch_req),
    .stall            (stall),
    .instr_q          (instr_q),
    .instr_valid      (instr_valid),
    .saidacontrolunit (saidacontrolunit),
    .saidaRs          (saidaRs),
    .saidaextendsinal (saidaextendsinal),
    .load_err         (load_err),
    .fault            (fault),
    .fault_code       (fault_code),
    .state_o          (state_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input logic rst, input logic we, input logic [7:0] la,
                              input logic [7:0] ld, input logic rs, input logic [7:0] pc,
                              input logic fr, input logic st);
    if (rst) begin
      m_mode = 0; m_instr = 8'h00; m_valid = 0; m_err = 0; m_fault = 0; m_code = 2'd0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
    end else if (m_mode == 0) begin
      m_err = 0;
      m_valid = 0;
      if (we) begin
        if (int'(la) < DEPTH) m_mem[la] = ld;
        else m_err = 1;
      end
      if (rs) m_mode = 1;
    end else if (m_mode == 1) begin
      m_err = we;
      if (!st) begin
        if (!fr) m_valid = 0;
        else if (int'(pc) >= DEPTH) begin
          m_mode = 2; m_instr = 8'h00; m_valid = 0; m_fault = 1; m_code = 2'd1;
        end else begin
          m_instr = m_mem[pc]; m_valid = 1;
        end
      end
    end else begin
      m_err = 0;
      m_valid = 0;
    end
  endtask

  task automatic compare_all();
    int imm;
    imm = int'(m_instr) % 32;
    if (imm >= 16) imm = imm - 32;
    chk("state",      {30'd0, state_o},      m_mode);
    chk("instr_q",    {24'd0, instr_q},      {24'd0, m_instr});
    chk("valid",      {31'd0, instr_valid},  {31'd0, m_valid});
    chk("load_err",   {31'd0, load_err},     {31'd0, m_err});
    chk("fault",      {31'd0, fault},        {31'd0, m_fault});
    chk("fault_code", {30'd0, fault_code},   {30'd0, m_code});
    chk("opcode",     {29'd0, saidacontrolunit}, int'(m_instr) / 32);
    chk("rs",         {30'd0, saidaRs},      (int'(m_instr) / 8) % 4);
    chk("imm_ext",    {24'd0, saidaextendsinal}, {24'd0, 8'(imm)});
  endtask

  task automatic step(input logic rst, input logic we, input logic [7:0] la,
                      input logic [7:0] ld, input logic rs, input logic [7:0] pc,
                      input logic fr, input logic st);
    reset = rst; load_we = we; load_addr = la; load_data = ld;
    run_start = rs; pccounter = pc; fetch_req = fr; stall = st;
    model_update(rst, we, la, ld, rs, pc, fr, st);
    @(posedge clock);
    #1;
    compare_all();
  endtask

  initial begin
    // reset: all outputs zero, LOAD
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("lit_reset_instr", {24'd0, instr_q}, 32'h0);
    chk("lit_reset_state", {30'd0, state_o}, 32'd0);

    step(0, 1, 8'd0, 8'b101_11011, 0, 0, 0, 0);
    step(0, 1, 8'd1, 8'h25, 0, 0, 1, 0);           // fetch_req ignored in LOAD
    chk("lit_load_valid", {31'd0, instr_valid}, 32'd0);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 8'd0, 1, 0);
    chk("lit_fetch0", {24'd0, instr_q}, 32'hBB);
    chk("lit_fetch0_valid", {31'd0, instr_valid}, 32'd1);
    chk("lit_opc", {29'd0, saidacontrolunit}, 32'd5);
    chk("lit_rs", {30'd0, saidaRs}, 32'd3);
    chk("lit_ext_fb", {24'd0, saidaextendsinal}, 32'hFB);
    step(0, 0, 0, 0, 0, 8'd1, 1, 1);
    chk("lit_stall_hold", {24'd0, instr_q}, 32'hBB);
    step(0, 0, 0, 0, 0, 8'd1, 1, 0);
    chk("lit_fetch1", {24'd0, instr_q}, 32'h25);
    chk("lit_ext_05", {24'd0, saidaextendsinal}, 32'h05);
    step(0, 0, 0, 0, 0, 8'd1, 0, 0);               // valid drops, instr holds
    step(0, 1, 8'd4, 8'h99, 1, 0, 0, 0);
    chk("lit_run_load_err", {31'd0, load_err}, 32'd1);
    step(0, 0, 0, 0, 0, 8'd4, 1, 0);
    chk("lit_run_load_dropped", {24'd0, instr_q}, 32'h00);

    // out-of-range load, then run_start with a simultaneous write
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 8'd16, 8'hAA, 0, 0, 0, 0);
    chk("lit_oor_load_err", {31'd0, load_err}, 32'd1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("lit_err_pulse_end", {31'd0, load_err}, 32'd0);
    step(0, 1, 8'd3, 8'h7F, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 8'd3, 1, 0);
    chk("lit_fetch3", {24'd0, instr_q}, 32'h7F);
    step(0, 0, 0, 0, 0, 8'd0, 1, 0);
    step(0, 0, 0, 0, 0, 8'd15, 1, 0);

    // reset coincident with fetch_req
    step(1, 0, 0, 0, 0, 8'd3, 1, 0);
    chk("lit_rst_fetch_valid", {31'd0, instr_valid}, 32'd0);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 8'd20, 1, 0);
    chk("lit_fault", {31'd0, fault}, 32'd1);
    chk("lit_fault_code", {30'd0, fault_code}, 32'd1);
    chk("lit_fault_state", {30'd0, state_o}, 32'd2);
    step(0, 1, 8'd2, 8'h11, 1, 8'd0, 1, 0);
    chk("lit_fault_sticky", {31'd0, fault}, 32'd1);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("lit_fault_cleared", {31'd0, fault}, 32'd0);

    // randomized phase
    for (int n = 0; n < 600; n++) begin
      logic r_rst, r_we, r_rs, r_fr, r_st;
      logic [7:0] r_la, r_ld, r_pc;
      r_rst = ($urandom_range(0, 59) == 0) || (m_mode == 2 && $urandom_range(0, 7) == 0);
      r_we  = $urandom_range(0, 2) == 0;
      r_la  = 8'($urandom_range(0, 19));
      r_ld  = 8'($urandom);
      r_rs  = $urandom_range(0, 11) == 0;
      r_pc  = ($urandom_range(0, 24) == 0) ? 8'($urandom_range(16, 255)) : 8'($urandom_range(0, 15));
      r_fr  = $urandom_range(0, 3) != 0;
      r_st  = $urandom_range(0, 4) == 0;
      step(r_rst, r_we, r_la, r_ld, r_rs, r_pc, r_fr, r_st);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
